x_delay_line_ctrl: RTL and testbench
====================================

# x_delay_line_ctrl

Measurement sequencer for the 32-tap delay line. It holds the delay line in reset while idle and releases it on command. After a flush interval it captures a programmable number of resynchronised tap words and decodes each into an edge position. It accumulates min/max/sum plus a bubble flag and presents the result through a valid/ready handshake.

## Interface

- SETTLE_CYCLES, default 4: cycles spent in SETTLE after releasing the delay line. Legal range 1..15.
- CNT_W, default 8: width of the sample-count field. The sum width is CNT_W+6.

- i_clk  input  1  clock.
- i_rst  input  1  reset: asynchronous, active-high. Clock is i_clk.
- i_start  input  1  start-measurement pulse. Sampled only in IDLE.
- i_abort  input  1  return to IDLE from any state.
- i_num_samples  input  CNT_W  number of samples to capture. Value 0 means 2^CNT_W samples. Latched on accepted start.
- i_data  input  32  resynchronised tap word from the delay line. Bit 0 is the launch tap.
- o_dl_rst  output  1  reset to the delay line. 1 in IDLE and DONE.
- o_busy  output  1  1 in SETTLE and SAMPLE.
- o_valid  output  1  result valid. 1 in DONE.
- i_ready  input  1  consumer accepts the result.
- o_min  output  6  smallest edge position seen.
- o_max  output  6  largest edge position seen.
- o_sum  output  CNT_W+6  sum of edge positions.
- o_bubble  output  1  1 if any sample was not a clean thermometer code.

## Operation

**States:** IDLE, SETTLE, SAMPLE, DONE. The state register is the only FSM storage.

**Transitions:**
- IDLE -> SETTLE when i_start=1 and i_abort=0.
  - i_num_samples is latched.
  - Accumulators are initialised: min=63, max=0, sum=0, bubble=0.
- SETTLE -> SAMPLE after SETTLE_CYCLES cycles. A settle counter is loaded on entry.
- SAMPLE -> DONE after the latched number of samples has been captured. One sample is taken per cycle.
- DONE -> IDLE when i_ready=1.
- Any state -> IDLE when i_abort=1. i_abort has priority over all other transitions.
- An abort never asserts o_valid. Result outputs keep their last values.
- i_start is ignored outside IDLE.

**Edge decode, combinational on i_data:**
- pos = index of the lowest bit i (1..31) with i_data[i] != i_data[0].
- If no such bit exists, pos = 32. Range is 1..32, 6 bits.
- The bubble condition holds when the count of adjacent-bit differences i_data[i]^i_data[i+1] (i=0..30) is greater than 1.

**Accumulation, each SAMPLE cycle:**
- min <= min(min, pos).
- max <= max(max, pos).
- sum <= sum + pos. The width CNT_W+6 cannot overflow: 256×32 = 8192 fits in 14 bits.
- bubble <= bubble | bubble condition.

o_min, o_max, o_sum and o_bubble are driven directly from the accumulators. They are meaningful only while o_valid=1.

## Timing

**Reset values:**
- State IDLE.
- o_dl_rst=1, o_busy=0, o_valid=0.
- o_min=63, o_max=0, o_sum=0, o_bubble=0.

**Cycle-level sequence:**
- Start accepted at edge N. The FSM is in SETTLE from N+1, and o_dl_rst=0 from N+1.
- SAMPLE starts at N+1+SETTLE_CYCLES and lasts exactly K cycles, where K is the latched count.
- o_valid=1 from N+1+SETTLE_CYCLES+K.
- The default SETTLE_CYCLES=4 covers the delay line's 2-stage output resync plus one launch-toggle cycle.
- All outputs are registered or decoded from state. There is no combinational path from i_ready or i_start to any output.

**Handshake:**
- Results are stable from o_valid rising until the o_valid&&i_ready edge.
- o_valid falls and o_dl_rst remains 1 on the cycle after acceptance.
- i_ready=1 while not in DONE has no effect.
- Back-to-back measurements: the earliest restart is i_start in the first IDLE cycle after acceptance.

**Boundary cases:**
- i_start and i_abort together in IDLE: the FSM stays in IDLE.
- i_abort in DONE together with i_ready: IDLE. The result is considered not consumed, and o_valid drops either way.
- Asynchronous reset mid-SAMPLE forces reset values immediately.

## Test plan

- **Basic run:** SETTLE_CYCLES=4, i_num_samples=4, i_data=32'h0000_00FF every cycle.
  - o_dl_rst falls 1 cycle after start.
  - o_valid rises 9 cycles after start.
  - o_min=8, o_max=8, o_sum=32, o_bubble=0.
- **Varying positions:** i_data sequence 32'h0000_000F, 32'hFFFF_FF00, 32'hFFFF_FFFF, with i_num_samples=3.
  - o_min=4, o_max=32, o_sum=44, o_bubble=0.
- **Bubble detection:** one sample 32'h0000_00F5 among clean samples.
  - o_bubble=1, and that sample's pos=1.
- **Zero count:** i_num_samples=0 with CNT_W=8 and constant 32'h0000_FFFF.
  - Exactly 256 SAMPLE cycles (o_busy high for 260 cycles).
  - o_sum=4096.
- **Handshake hold:** hold i_ready=0 for 10 cycles in DONE.
  - Outputs are stable throughout, and i_start is ignored.
  - i_ready=1 gives IDLE next cycle, o_valid=0, o_dl_rst=1.
- **Abort and reset:**
  - i_abort in the 2nd SAMPLE cycle gives IDLE next cycle with o_valid never asserted.
  - i_rst pulsed mid-SETTLE gives all outputs at reset values asynchronously.

Source files
------------

// File: rtl/x_delay_line_ctrl.sv
// Measurement sequencer for a 32-tap delay line: holds the line in reset while idle,
// then settles, samples N tap words, and accumulates min/max/sum/bubble statistics.
module x_delay_line_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [CNT_W-1:0]   i_num_samples,
  input  logic [31:0]        i_data,
  output logic               o_dl_rst,
  output logic               o_busy,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [5:0]         o_min,
  output logic [5:0]         o_max,
  output logic [CNT_W+5:0]   o_sum,
  output logic               o_bubble
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_settle_cnt;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [5:0]         r_min;
  logic [5:0]         r_max;
  logic [CNT_W+5:0]   r_sum;
  logic               r_bubble;

  logic               w_accept;
  logic               w_settle_done;
  logic               w_sample_last;
  logic               w_sample_en;
  logic [31:0]        w_diff;
  logic [30:0]        w_trans;
  logic [5:0]         w_pos;
  logic               w_bubble;

  // Edge decode: bits that disagree with the launch tap, and adjacent-tap transitions.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_diff
      assign w_diff[gi] = i_data[gi] ^ i_data[0];
    end
    for (gi = 0; gi < 31; gi++) begin : g_trans
      assign w_trans[gi] = i_data[gi] ^ i_data[gi+1];
    end
  endgenerate

  always_comb begin
    w_pos = 6'd32;
    for (int i = 31; i >= 1; i--) begin
      if (w_diff[i]) w_pos = 6'(i);
    end
  end

  // More than one transition: clearing the lowest set bit leaves something behind.
  assign w_bubble = |(w_trans & (w_trans - 31'd1));

  assign w_accept      = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_settle_done = (r_settle_cnt == 4'd0);
  assign w_sample_last = (r_sample_cnt == '0);
  assign w_sample_en   = (r_state == S_SAMPLE) && !i_abort;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start)       w_state_next = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_state_next = S_SAMPLE;
      S_SAMPLE: if (w_sample_last) w_state_next = S_DONE;
      S_DONE:   if (i_ready)       w_state_next = S_IDLE;
      default:                     w_state_next = S_IDLE;
    endcase
    if (i_abort) w_state_next = S_IDLE;
  end

  // The sample counter holds count-1, so a requested count of 0 wraps to 2^CNT_W samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_settle_cnt <= '0;
      r_sample_cnt <= '0;
    end else begin
      if (w_accept)
        r_settle_cnt <= 4'(SETTLE_CYCLES - 1);
      else if (r_state == S_SETTLE && !w_settle_done)
        r_settle_cnt <= r_settle_cnt - 4'd1;

      if (w_accept)
        r_sample_cnt <= i_num_samples - CNT_W'(1);
      else if (w_sample_en)
        r_sample_cnt <= r_sample_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_min    <= 6'd63;
      r_max    <= 6'd0;
      r_sum    <= '0;
      r_bubble <= 1'b0;
    end else if (w_accept) begin
      r_min    <= 6'd63;
      r_max    <= 6'd0;
      r_sum    <= '0;
      r_bubble <= 1'b0;
    end else if (w_sample_en) begin
      if (w_pos < r_min) r_min <= w_pos;
      if (w_pos > r_max) r_max <= w_pos;
      r_sum    <= r_sum + {{CNT_W{1'b0}}, w_pos};
      r_bubble <= r_bubble | w_bubble;
    end
  end

  assign o_dl_rst = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_busy   = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign o_valid  = (r_state == S_DONE);
  assign o_min    = r_min;
  assign o_max    = r_max;
  assign o_sum    = r_sum;
  assign o_bubble = r_bubble;

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Self-checking bench for x_delay_line_ctrl: table vectors, hand-written corner
// sequences and randomized runs against a behavioural model.
module tb_x_delay_line_ctrl;
  localparam int S     = 4;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort_in;
  logic [CNT_W-1:0]  num_samples;
  logic [31:0]       data;
  logic              dl_rst, busy, valid;
  logic              ready;
  logic [5:0]        min_o, max_o;
  logic [CNT_W+5:0]  sum_o;
  logic              bubble_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] samp [0:255];

  x_delay_line_ctrl #(.SETTLE_CYCLES(S), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_in),
    .i_num_samples(num_samples), .i_data(data),
    .o_dl_rst(dl_rst), .o_busy(busy), .o_valid(valid), .i_ready(ready),
    .o_min(min_o), .o_max(max_o), .o_sum(sum_o), .o_bubble(bubble_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] pat [3];
    int          hold;
    logic [5:0]  emin;
    logic [5:0]  emax;
    int          esum;
    logic        ebub;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference edge position: first tap disagreeing with the launch tap.
  function automatic int ref_pos(input logic [31:0] d);
    for (int i = 1; i < 32; i++) if (d[i] != d[0]) return i;
    return 32;
  endfunction

  function automatic bit ref_bub(input logic [31:0] d);
    int t = 0;
    for (int i = 0; i < 31; i++) if (d[i] != d[i+1]) t++;
    return t > 1;
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] ones = '1;
    logic [31:0] w;
    int p;
    if ($urandom_range(0, 3) == 0) return $urandom;
    p = $urandom_range(1, 32);
    w = (p == 32) ? 32'h0 : (ones << p);
    if ($urandom_range(0, 1) == 1) w = ~w;
    return w;
  endfunction

  // One measurement: start, check flags every cycle, feed samp[], check result,
  // hold in DONE for 'hold' cycles with start poked, then accept (or abort+ready).
  task automatic run_meas(input int n, input int hold, input bit abort_done,
                          input logic [5:0] emin, input logic [5:0] emax,
                          input int esum, input logic ebub);
    int k;
    logic [31:0] res;
    k = (n == 0) ? 256 : n;
    res = {5'd0, ebub, 14'(esum), emax, emin};
    num_samples = CNT_W'(n);
    start = 1'b1;
    data = $urandom;
    step();
    start = 1'b0;
    num_samples = CNT_W'($urandom);
    for (int j = 0; j <= S + k; j++) begin
      chk("flags_run", {dl_rst, busy, valid}, (j < S + k) ? 3'b010 : 3'b101);
      if (j >= S && j < S + k) data = samp[j - S];
      else data = $urandom;
      if (j < S + k) step();
    end
    chk("result", {5'd0, bubble_o, sum_o, max_o, min_o}, res);
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      ready = 1'b0;
      data = $urandom;
      step();
      chk("hold_flags", {dl_rst, busy, valid}, 3'b101);
      chk("hold_result", {5'd0, bubble_o, sum_o, max_o, min_o}, res);
    end
    start = 1'b0;
    ready = 1'b1;
    abort_in = abort_done;
    step();
    ready = 1'b0;
    abort_in = 1'b0;
    chk(abort_done ? "abort_done" : "accept", {dl_rst, busy, valid}, 3'b100);
  endtask

  vec_t vecs [6];

  initial begin
    int         k, p;
    logic [5:0] mn, mx;
    int         sm;
    logic       bb;

    vecs[0] = '{n:4, pat:'{32'h0000_00FF, 32'h0000_00FF, 32'h0000_00FF}, hold:10,
                emin:8, emax:8, esum:32, ebub:0};
    vecs[1] = '{n:3, pat:'{32'h0000_000F, 32'hFFFF_FF00, 32'hFFFF_FFFF}, hold:0,
                emin:4, emax:32, esum:44, ebub:0};
    vecs[2] = '{n:3, pat:'{32'h0000_00FF, 32'h0000_00F5, 32'h0000_00FF}, hold:2,
                emin:1, emax:8, esum:17, ebub:1};
    vecs[3] = '{n:0, pat:'{32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF}, hold:1,
                emin:16, emax:16, esum:4096, ebub:0};
    vecs[4] = '{n:1, pat:'{32'h8000_0000, 32'h0, 32'h0}, hold:0,
                emin:31, emax:31, esum:31, ebub:0};
    vecs[5] = '{n:2, pat:'{32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0}, hold:0,
                emin:1, emax:31, esum:32, ebub:0};

    rst = 1'b1; start = 1'b0; abort_in = 1'b0; ready = 1'b0;
    num_samples = '0; data = '0;
    step(); step();
    chk("reset_flags", {dl_rst, busy, valid}, 3'b100);
    chk("reset_result", {5'd0, bubble_o, sum_o, max_o, min_o}, {5'd0, 1'b0, 14'd0, 6'd0, 6'd63});
    rst = 1'b0;
    step();

    // Ready while idle does nothing.
    ready = 1'b1; step(); ready = 1'b0;
    chk("idle_ready", {dl_rst, busy, valid}, 3'b100);

    for (int v = 0; v < 6; v++) begin
      k = (vecs[v].n == 0) ? 256 : vecs[v].n;
      for (int i = 0; i < k; i++) samp[i] = vecs[v].pat[i % 3];
      run_meas(vecs[v].n, vecs[v].hold, 1'b0, vecs[v].emin, vecs[v].emax,
               vecs[v].esum, vecs[v].ebub);
    end

    // Start together with abort in IDLE stays in IDLE.
    start = 1'b1; abort_in = 1'b1; num_samples = 8'd5;
    step();
    start = 1'b0; abort_in = 1'b0;
    chk("start_abort_idle", {dl_rst, busy, valid}, 3'b100);
    step();
    chk("start_abort_idle2", {dl_rst, busy, valid}, 3'b100);

    // Abort during the 2nd SAMPLE cycle; valid must never appear afterwards.
    num_samples = 8'd10; start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j <= S + 1; j++) begin
      chk("abort_run_flags", {dl_rst, busy, valid}, 3'b010);
      data = gen_word();
      if (j == S + 1) abort_in = 1'b1;
      step();
    end
    abort_in = 1'b0;
    chk("abort_sample", {dl_rst, busy, valid}, 3'b100);
    p = 0;
    for (int j = 0; j < 15; j++) begin
      step();
      if (valid) p++;
    end
    chk("abort_no_valid", p, 0);

    // Abort together with ready in DONE.
    for (int i = 0; i < 2; i++) samp[i] = 32'h0000_0003;
    run_meas(2, 1, 1'b1, 6'd2, 6'd2, 4, 1'b0);

    // Asynchronous reset in the middle of SETTLE.
    num_samples = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("settle_before_rst", {dl_rst, busy, valid}, 3'b010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flags", {dl_rst, busy, valid}, 3'b100);
    chk("async_rst_result", {5'd0, bubble_o, sum_o, max_o, min_o}, {5'd0, 1'b0, 14'd0, 6'd0, 6'd63});
    #2 rst = 1'b0;
    step();
    chk("after_rst_idle", {dl_rst, busy, valid}, 3'b100);

    // Randomized runs against the behavioural model.
    for (int r = 0; r < 25; r++) begin
      k = $urandom_range(1, 20);
      mn = 6'd63; mx = 6'd0; sm = 0; bb = 1'b0;
      for (int i = 0; i < k; i++) begin
        samp[i] = gen_word();
        p = ref_pos(samp[i]);
        if (p < mn) mn = 6'(p);
        if (p > mx) mx = 6'(p);
        sm += p;
        bb |= ref_bub(samp[i]);
      end
      run_meas(k, $urandom_range(0, 3), 1'b0, mn, mx, sm, bb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
